// File: rtl/mdu_ctrl_pkg.sv
// Shared constants for the multiply/divide unit: operation codes, FSM
// state encodings and small helpers classifying operations.
package mdu_ctrl_pkg;

   // Operation codes presented on the op port
   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   // Controller FSM state encodings
   localparam logic [0:0] MDU_IDLE = 1'b0;
   localparam logic [0:0] MDU_RUN  = 1'b1;

   // Operations that run a multi-cycle sequence and commit to HI/LO at the end
   function automatic logic isSeqOp(input logic [2:0] opCode);
      return (opCode == MDU_MULT) || (opCode == MDU_MULTU) ||
             (opCode == MDU_DIV)  || (opCode == MDU_DIVU);
   endfunction

   // Operations that use the divide latency
   function automatic logic isDivOp(input logic [2:0] opCode);
      return (opCode == MDU_DIV) || (opCode == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational datapath of the MDU. Produces the 64-bit {HI,LO} result
// for multiply/divide operations plus a flag for division by zero.
module mdu_arith
   import mdu_ctrl_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [2:0]  op_i,
   output logic [63:0] result_o,
   output logic        divByZero_o
);

   logic signed [63:0] aWide;
   logic signed [63:0] bWide;
   logic signed [31:0] quoS;
   logic signed [31:0] remS;

   // Sign-extended operands so the signed product is formed at full width
   assign aWide = {{32{a_i[31]}}, a_i};
   assign bWide = {{32{b_i[31]}}, b_i};

   // Result selection; HI carries the upper product half or the remainder,
   // LO carries the lower product half or the quotient. The most negative
   // dividend over -1 overflows a 32-bit signed divide, so it is resolved
   // explicitly rather than left to the divider.
   always_comb begin
      result_o    = '0;
      divByZero_o = 1'b0;
      quoS        = '0;
      remS        = '0;
      case (op_i)
         MDU_MULT: begin
            result_o = aWide * bWide;
         end
         MDU_MULTU: begin
            result_o = {32'h0, a_i} * {32'h0, b_i};
         end
         MDU_DIV: begin
            if (b_i == 32'h0) begin
               divByZero_o = 1'b1;
            end else if ((a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF)) begin
               result_o = {32'h0, 32'h8000_0000};
            end else begin
               quoS     = $signed(a_i) / $signed(b_i);
               remS     = $signed(a_i) % $signed(b_i);
               result_o = {remS, quoS};
            end
         end
         MDU_DIVU: begin
            if (b_i == 32'h0) begin
               divByZero_o = 1'b1;
            end else begin
               result_o = {a_i % b_i, a_i / b_i};
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller. Owns HI/LO, captures the arithmetic
// result when a request starts, holds busy for a fixed latency and commits
// the pending result to HI/LO as the sequence ends.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [0:0]       state_q,        state_d;
   logic [CNT_W-1:0] count_q,        count_d;
   logic [31:0]      pendingHi_q,    pendingHi_d;
   logic [31:0]      pendingLo_q,    pendingLo_d;
   logic             pendingValid_q, pendingValid_d;
   logic [31:0]      hi_q,           hi_d;
   logic [31:0]      lo_q,           lo_d;

   logic [63:0]      arithResult;
   logic             arithDivByZero;

   mdu_arith uArith (
      .a_i         (a),
      .b_i         (b),
      .op_i        (op),
      .result_o    (arithResult),
      .divByZero_o (arithDivByZero)
   );

   // Next-state logic: requests are only taken in IDLE; a RUN sequence ends
   // when the counter reaches one, committing the pending result unless the
   // divisor was zero
   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      pendingHi_d    = pendingHi_q;
      pendingLo_d    = pendingLo_q;
      pendingValid_d = pendingValid_q;
      hi_d           = hi_q;
      lo_d           = lo_q;
      case (state_q)
         MDU_IDLE: begin
            if (start) begin
               if (isSeqOp(op)) begin
                  pendingHi_d    = arithResult[63:32];
                  pendingLo_d    = arithResult[31:0];
                  pendingValid_d = !arithDivByZero;
                  count_d        = isDivOp(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  state_d        = MDU_RUN;
               end else if (op == MDU_MTHI) begin
                  hi_d = a;
               end else if (op == MDU_MTLO) begin
                  lo_d = a;
               end
            end
         end
         MDU_RUN: begin
            if (count_q == CNT_W'(1)) begin
               if (pendingValid_q) begin
                  hi_d = pendingHi_q;
                  lo_d = pendingLo_q;
               end
               count_d = '0;
               state_d = MDU_IDLE;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = MDU_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any sequence in flight without commit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= MDU_IDLE;
         count_q        <= '0;
         pendingHi_q    <= '0;
         pendingLo_q    <= '0;
         pendingValid_q <= 1'b0;
         hi_q           <= '0;
         lo_q           <= '0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         pendingHi_q    <= pendingHi_d;
         pendingLo_q    <= pendingLo_d;
         pendingValid_q <= pendingValid_d;
         hi_q           <= hi_d;
         lo_q           <= lo_d;
      end
   end

   assign busy = (state_q == MDU_RUN);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
